// File: rtl/raymarch_pkg.sv
// Shared types and constants for the raymarch frame scheduler.
package raymarch_pkg;

    localparam int unsigned RGB_W = 24;

    typedef logic [1:0] sched_state_t;
    localparam sched_state_t IDLE     = 2'd0;
    localparam sched_state_t DISPATCH = 2'd1;
    localparam sched_state_t DRAIN    = 2'd2;
    localparam sched_state_t DONE     = 2'd3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-wide round-robin arbiter: one-hot grant, pointer moves to granted index + 1.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt_c,
    output logic [PW-1:0] gnt_idx_c
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cand;
    int unsigned   idx;
    logic          found;

    // Search starting at the pointer, wrapping at N.
    always_comb begin : grant
        gnt_c     = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        idx       = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found       = 1'b1;
                gnt_c[cand] = 1'b1;
                gnt_idx_c   = cand;
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx_c == PW'(N - 1)) ? '0 : gnt_idx_c + PW'(1);
        end
    end

    always_ff @(posedge clk) begin : ptr_reg
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/raymarch_scheduler.sv
// Frame scheduler: raster dispatch to NUM_CORES cores, round-robin framebuffer writeback.
// Optional frame cycle counter enabled by RAYMARCH_SCHED_PERF_EN.
module raymarch_scheduler
    import raymarch_pkg::*;
#(
    parameter int unsigned WIDTH     = 1280,
    parameter int unsigned HEIGHT    = 720,
    parameter int unsigned NUM_CORES = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic                             frame_start_in,
    output logic                             frame_busy_out,
    output logic                             frame_done_out,
    output logic [NUM_CORES-1:0]             core_start_out,
    output logic [$clog2(WIDTH)-1:0]         core_x_out,
    output logic [$clog2(HEIGHT)-1:0]        core_y_out,
    input  logic [NUM_CORES-1:0]             core_done_in,
    input  logic [RGB_W*NUM_CORES-1:0]       core_rgb_in,
    output logic                             fb_we_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]  fb_addr_out,
    output logic [RGB_W-1:0]                 fb_data_out,
    output logic [31:0]                      frame_cycles_out
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned AW = $clog2(WIDTH * HEIGHT);
    localparam int unsigned PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    sched_state_t state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [NUM_CORES-1:0] busy_q, busy_d;
    logic [NUM_CORES-1:0] pend_q, pend_d;
    logic [NUM_CORES-1:0][XW-1:0] cx_q, cx_d;
    logic [NUM_CORES-1:0][YW-1:0] cy_q, cy_d;
    rgb_t [NUM_CORES-1:0] rgb_q, rgb_d;
    logic fb_we_q, fb_we_d;
    logic [AW-1:0] fb_addr_q, fb_addr_d;
    rgb_t fb_data_q, fb_data_d;

    logic          free_any_c;
    logic [PW-1:0] free_idx_c;
    logic          dispatch_c;
    logic [NUM_CORES-1:0] gnt_c;
    logic [PW-1:0]        gnt_idx_c;

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_wb_arb (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .req       (pend_q),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c)
    );

    // Lowest-index idle core.
    always_comb begin : find_free
        free_any_c = 1'b0;
        free_idx_c = '0;
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_any_c = 1'b1;
                free_idx_c = PW'(i);
            end
        end
    end

    assign dispatch_c     = (state_q == DISPATCH) && free_any_c;
    assign core_start_out = dispatch_c ? (NUM_CORES'(1) << free_idx_c) : '0;
    assign core_x_out     = dispatch_c ? x_q : '0;
    assign core_y_out     = dispatch_c ? y_q : '0;
    assign frame_busy_out = (state_q != IDLE);
    assign frame_done_out = (state_q == DONE);
    assign fb_we_out      = fb_we_q;
    assign fb_addr_out    = fb_addr_q;
    assign fb_data_out    = fb_data_q;

    always_comb begin : next_state
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        busy_d    = busy_q;
        pend_d    = pend_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        rgb_d     = rgb_q;
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;

        case (state_q)
            IDLE: begin
                if (frame_start_in) begin
                    state_d = DISPATCH;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            DISPATCH: begin
                if (dispatch_c) begin
                    cx_d[free_idx_c]   = x_q;
                    cy_d[free_idx_c]   = y_q;
                    busy_d[free_idx_c] = 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            y_d = y_q + YW'(1);
                        end
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            DRAIN: begin
                if ((busy_q == '0) && (pend_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Results from idle cores are stray pulses and are dropped.
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (core_done_in[i] && busy_q[i]) begin
                pend_d[i] = 1'b1;
                rgb_d[i]  = rgb_t'(core_rgb_in[RGB_W*i +: RGB_W]);
            end
        end

        // Core stays busy until its pixel is actually written.
        if (|gnt_c) begin
            fb_we_d   = 1'b1;
            fb_addr_d = AW'(AW'(cy_q[gnt_idx_c]) * AW'(WIDTH)) + AW'(cx_q[gnt_idx_c]);
            fb_data_d = rgb_q[gnt_idx_c];
            pend_d[gnt_idx_c] = 1'b0;
            busy_d[gnt_idx_c] = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin : regs
        if (!rst_n_in) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            busy_q    <= '0;
            pend_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            rgb_q     <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            pend_q    <= pend_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            rgb_q     <= rgb_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
        end
    end

`ifdef RAYMARCH_SCHED_PERF_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] frame_cycles_q, frame_cycles_d;

    // Captured value includes the done cycle itself, i.e. the full busy duration.
    always_comb begin : perf_next
        cyc_cnt_d      = cyc_cnt_q;
        frame_cycles_d = frame_cycles_q;
        if ((state_q == IDLE) && frame_start_in) begin
            cyc_cnt_d = '0;
        end else if (state_q != IDLE) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
        if (state_q == DONE) begin
            frame_cycles_d = cyc_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in) begin : perf_regs
        if (!rst_n_in) begin
            cyc_cnt_q      <= '0;
            frame_cycles_q <= '0;
        end else begin
            cyc_cnt_q      <= cyc_cnt_d;
            frame_cycles_q <= frame_cycles_d;
        end
    end

    assign frame_cycles_out = frame_cycles_q;
`else
    assign frame_cycles_out = '0;
`endif

endmodule

// File: tb/tb_raymarch_scheduler.sv
// Bench for raymarch_scheduler (4x2 frame, 2 cores) against a cycle-level reference model.
module tb_raymarch_scheduler;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned N  = 2;
    localparam int          NC = 2;
    localparam int          NPIX = 8;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic            frame_start_in;
    logic            frame_busy_out;
    logic            frame_done_out;
    logic [N-1:0]    core_start_out;
    logic [1:0]      core_x_out;
    logic [0:0]      core_y_out;
    logic [N-1:0]    core_done_in;
    logic [24*N-1:0] core_rgb_in;
    logic            fb_we_out;
    logic [2:0]      fb_addr_out;
    logic [23:0]     fb_data_out;
    logic [31:0]     frame_cycles_out;

    raymarch_scheduler #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .NUM_CORES (N)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .frame_start_in   (frame_start_in),
        .frame_busy_out   (frame_busy_out),
        .frame_done_out   (frame_done_out),
        .core_start_out   (core_start_out),
        .core_x_out       (core_x_out),
        .core_y_out       (core_y_out),
        .core_done_in     (core_done_in),
        .core_rgb_in      (core_rgb_in),
        .fb_we_out        (fb_we_out),
        .fb_addr_out      (fb_addr_out),
        .fb_data_out      (fb_data_out),
        .frame_cycles_out (frame_cycles_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: what the scheduler should be doing in the current cycle.
    bit  m_busy [NC];
    bit  m_pend [NC];
    int  m_pix  [NC];
    int  done_at[NC];
    int  m_ptr, m_px, m_wr_pix, busy_cnt, wr_cnt, lat_mode;
    bit  m_frame, m_disp, m_drain, m_done_now, m_wr_v;
    bit [NPIX-1:0] wr_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix_rgb(input int p);
        return {8'h00, 8'(p % int'(W)), 8'(p / int'(W))};
    endfunction

    function automatic int latency(input int c);
        case (lat_mode)
            0:       return 5;
            1:       return int'($urandom_range(8, 1));
            2:       return 6 - c;
            default: return 1 << 30;
        endcase
    endfunction

    task automatic reset_model();
        for (int k = 0; k < NC; k++) begin
            m_busy[k] = 1'b0;
            m_pend[k] = 1'b0;
            m_pix[k]  = 0;
        end
        m_ptr = 0; m_px = 0; m_wr_pix = 0; busy_cnt = 0; wr_cnt = 0;
        m_frame = 1'b0; m_disp = 1'b0; m_drain = 1'b0; m_done_now = 1'b0; m_wr_v = 1'b0;
        wr_seen = '0;
    endtask

    // Check this cycle's outputs, advance the model, drive inputs, move to next negedge.
    task automatic step(input bit start);
        bit pre_busy [NC];
        bit any_busy, done_next, frame_cur;
        int e, g, c;
        logic [N-1:0] dn;

        check("fb_we", 32'(fb_we_out), 32'(m_wr_v));
        if (m_wr_v) begin
            check("fb_addr", 32'(fb_addr_out), 32'(m_wr_pix));
            check("fb_data", 32'(fb_data_out), 32'(pix_rgb(m_wr_pix)));
        end
        if (fb_we_out === 1'b1) begin
            wr_cnt++;
            wr_seen[fb_addr_out] = 1'b1;
        end
        check("frame_done", 32'(frame_done_out), 32'(m_done_now));
        check("frame_busy", 32'(frame_busy_out), 32'(m_frame));

        e = -1;
        if (m_disp) begin
            for (int k = NC - 1; k >= 0; k--) begin
                if (!m_busy[k]) e = k;
            end
        end
        check("core_start", 32'(core_start_out), (e >= 0) ? (32'd1 << e) : 32'd0);
        if (e >= 0) begin
            check("core_x", 32'(core_x_out), 32'(m_px % int'(W)));
            check("core_y", 32'(core_y_out), 32'(m_px / int'(W)));
        end

        frame_cur = m_frame;
        if (m_frame) busy_cnt++;
        any_busy = 1'b0;
        for (int k = 0; k < NC; k++) begin
            pre_busy[k] = m_busy[k];
            any_busy    = any_busy | m_busy[k];
        end
        done_next = m_drain && !any_busy;

        g = -1;
        for (int k = 0; k < NC; k++) begin
            c = (m_ptr + k) % NC;
            if (g < 0 && m_pend[c]) g = c;
        end
        m_wr_v = (g >= 0);
        if (g >= 0) begin
            m_wr_pix  = m_pix[g];
            m_pend[g] = 1'b0;
            m_busy[g] = 1'b0;
            m_ptr     = (g + 1) % NC;
        end

        if (e >= 0) begin
            m_busy[e]  = 1'b1;
            m_pix[e]   = m_px;
            done_at[e] = cyc + latency(e);
            m_px++;
            if (m_px == NPIX) begin
                m_disp  = 1'b0;
                m_drain = 1'b1;
            end
        end
        if (done_next) m_drain = 1'b0;
        if (m_done_now) m_frame = 1'b0;
        m_done_now = done_next;
        if (start && !frame_cur) begin
            m_frame = 1'b1; m_disp = 1'b1; m_px = 0;
            busy_cnt = 0; wr_cnt = 0; wr_seen = '0;
        end

        dn = '0;
        for (int k = 0; k < NC; k++) begin
            if (done_at[k] == cyc) begin
                dn[k] = 1'b1;
                core_rgb_in[24*k +: 24] = pix_rgb(m_pix[k]);
                if (pre_busy[k]) m_pend[k] = 1'b1;
            end
        end
        core_done_in   = dn;
        frame_start_in = start;
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0; frame_start_in = 1'b0; core_done_in = '0;
        @(negedge clk_in);
        cyc++;
        reset_model();
        check("rst_core_start", 32'(core_start_out), 32'd0);
        check("rst_core_x", 32'(core_x_out), 32'd0);
        check("rst_core_y", 32'(core_y_out), 32'd0);
        check("rst_fb_we", 32'(fb_we_out), 32'd0);
        check("rst_fb_addr", 32'(fb_addr_out), 32'd0);
        check("rst_fb_data", 32'(fb_data_out), 32'd0);
        check("rst_busy", 32'(frame_busy_out), 32'd0);
        check("rst_done", 32'(frame_done_out), 32'd0);
        check("rst_cycles", frame_cycles_out, 32'd0);
        rst_n_in = 1'b1;
    endtask

    task automatic finish_frame();
        int n = 0;
        while (m_frame && n < 400) begin
            step(1'b0);
            n++;
        end
        check("frame_timeout", 32'(m_frame), 32'd0);
        check("wr_count", 32'(wr_cnt), 32'(NPIX));
        check("wr_cover", 32'(wr_seen), 32'hff);
`ifdef RAYMARCH_SCHED_PERF_EN
        check("frame_cycles", frame_cycles_out, 32'(busy_cnt));
`else
        check("frame_cycles", frame_cycles_out, 32'd0);
`endif
    endtask

    initial begin
        int n;
        rst_n_in = 1'b0; frame_start_in = 1'b0; core_done_in = '0; core_rgb_in = '0;
        for (int k = 0; k < NC; k++) done_at[k] = -1;
        lat_mode = 0;
        do_reset();
        repeat (2) step(1'b0);

        // Fixed 5-cycle latency frame.
        step(1'b1);
        finish_frame();
        repeat (2) step(1'b0);

        // Latencies that make both cores finish in the same cycle.
        lat_mode = 2;
        step(1'b1);
        finish_frame();
        step(1'b0);

        // Cores stall: no dispatch, frame stays busy, raster position holds.
        lat_mode = 3;
        step(1'b1);
        repeat (55) step(1'b0);
        lat_mode = 0;
        for (int k = 0; k < NC; k++) begin
            if (m_busy[k]) done_at[k] = cyc;
        end
        finish_frame();

        // Random core latencies; a start during the done cycle is ignored.
        lat_mode = 1;
        repeat (3) begin
            step(1'b1);
            finish_frame();
        end
        step(1'b1);
        n = 0;
        while (!m_done_now && n < 400) begin
            step(1'b0);
            n++;
        end
        step(1'b1);
        repeat (3) step(1'b0);

        // Reset after three dispatches aborts the frame silently.
        lat_mode = 0;
        step(1'b1);
        n = 0;
        while (m_px < 3 && n < 100) begin
            step(1'b0);
            n++;
        end
        check("mid_reset_reach", 32'(m_px), 32'd3);
        do_reset();
        repeat (12) step(1'b0);
        step(1'b1);
        finish_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/raymarch_scheduler.md
Name: raymarch_scheduler

Overview:
- Frame-level controller that shares NUM_CORES raymarcher cores across one frame.
- Walks pixels in raster order and dispatches each pixel's (x, y) to an idle core with a start pulse.
- Collects each core's RGB result and arbitrates the results onto a single framebuffer write port.
- Sits between the frame/display control logic and the array of raymarcher cores.

Parameters:
- WIDTH, 1280, frame width in pixels.
- HEIGHT, 720, frame height in pixels.
- NUM_CORES, 4, number of raymarcher cores managed; legal range 1..16.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset; synchronous, active-low.
- frame_start_in  input  1  one-cycle pulse that starts a frame; ignored while frame_busy_out=1.
- frame_busy_out  output  1  high from the cycle after an accepted frame_start_in until frame_done_out.
- frame_done_out  output  1  one-cycle pulse when the last pixel of the frame has been written.
- core_start_out  output  NUM_CORES  one-hot, one-cycle start pulse per core.
- core_x_out  output  $clog2(WIDTH)  pixel x, shared bus, valid with core_start_out.
- core_y_out  output  $clog2(HEIGHT)  pixel y, shared bus, valid with core_start_out.
- core_done_in  input  NUM_CORES  per-core one-cycle result-valid pulse.
- core_rgb_in  input  24*NUM_CORES  per-core {r,g,b}; core i occupies bits [24i+23:24i]; valid with core_done_in[i].
- fb_we_out  output  1  framebuffer write enable.
- fb_addr_out  output  $clog2(WIDTH*HEIGHT)  write address = y*WIDTH + x.
- fb_data_out  output  24  {r,g,b} write data.
- frame_cycles_out  output  32  cycle count of the last completed frame (see Optional Feature).

Behaviour:
- Reset (rst_n_in=0 at a clock edge): state IDLE; all outputs 0; busy, pending, raster counters and round-robin pointer cleared.
- Reset mid-frame aborts the frame silently: no frame_done_out, no further fb writes.
- FSM states:
  - IDLE: an accepted frame_start_in clears the raster counters and moves to DISPATCH.
  - DISPATCH: moves to DRAIN in the cycle the last pixel (WIDTH-1, HEIGHT-1) is dispatched.
  - DRAIN: moves to DONE when no core is busy and no result is pending.
  - DONE: pulses frame_done_out for one cycle, then returns to IDLE.
- Per-core tracking: busy bit, pending bit, latched pixel coordinate, latched rgb.
  - A core is busy from its dispatch until its result has been written to the framebuffer, not merely until core_done_in.
- Dispatch, DISPATCH state only:
  - At most one dispatch per cycle, to the lowest-index core with busy=0.
  - In that cycle: core_start_out bit set, core_x_out/core_y_out driven, core coordinate latched, busy set.
  - Raster x increments; wrap at WIDTH-1 to 0 with y increment.
  - If all cores are busy, nothing is dispatched and the counters hold.
- First dispatch occurs the cycle after frame_start_in is accepted (1-cycle latency).
- core_done_in[i]:
  - Latches rgb and sets pending[i].
  - If core i is not busy, the pulse is ignored.
  - Multiple dones in the same cycle are all latched.
- Writeback:
  - At most one write per cycle, chosen round-robin among pending cores, starting from the pointer.
  - The pointer advances to the granted index + 1, wrapping at NUM_CORES.
  - fb_we_out, fb_addr_out and fb_data_out are registered: asserted the cycle after pending is set at the earliest.
  - A granted core has pending and busy cleared in the same edge.
  - A freed core is eligible for dispatch the following cycle; there is no same-cycle write-then-dispatch bypass.
- Address arithmetic: unsigned; y*WIDTH computed with a full-width product. The final pixel address is WIDTH*HEIGHT-1.
- fb_we_out is low whenever nothing is granted. fb_addr_out and fb_data_out hold their last values.

Optional Feature:
- Macro: RAYMARCH_SCHED_PERF_EN.
- Defined:
  - A 32-bit counter clears on the accepted frame_start_in and increments every cycle while frame_busy_out=1.
  - frame_cycles_out is loaded from the counter on frame_done_out and holds until the next completed frame.
  - Reset clears both counter and output.
- Not defined: frame_cycles_out is constant 0 and no counter logic is synthesized.

Decomposition:
- Package raymarch_pkg holds:
  - typedef sched_state_t {IDLE, DISPATCH, DRAIN, DONE};
  - constant RGB_W=24;
  - typedef rgb_t as a 24-bit packed struct {r,g,b}.
- One sub-module: rr_arbiter (NUM_CORES-wide round-robin grant, one-hot out, pointer register inside). It is reused later for sharing SDF units.

Test Plan:
- Reset to first dispatch: WIDTH=4, HEIGHT=2, NUM_CORES=2, reset then frame_start_in -> core_start_out=01 with (0,0) the next cycle, then 10 with (1,0), then no start until a done arrives.
- Full-frame ordering: cores return done 5 cycles after start with rgb=0x00XXYY=(x,y) -> exactly 8 fb writes, addr == y*4+x, data matches, frame_done_out exactly once.
- Simultaneous done: both cores pulse done in the same cycle -> two writes on consecutive cycles, core0 first, and core1 first on the next collision (round-robin).
- Stall: hold all cores without done for 50 cycles -> no core_start_out, raster counters unchanged, frame_busy_out=1.
- Reset mid-frame: rst_n_in low after 3 dispatches -> next cycle all outputs 0, no frame_done_out. A new frame_start_in then restarts at (0,0).
- With RAYMARCH_SCHED_PERF_EN defined: fixed 5-cycle core latency, 4x2 frame -> frame_cycles_out equals the measured busy duration. Without the macro -> frame_cycles_out stays 0.
